// File: rtl/bf16_pkg.sv
// Shared BF16 datapath constants and types for the adder's normalize/round stages.
package bf16_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;
    localparam logic [EXP_W-1:0] EXP_INF = '1;

    // Field offsets inside the raw adder sum {carry, hidden, mantissa, G, R, S}
    localparam int SUM_W      = MAN_W + 5;
    localparam int SUM_CARRY  = MAN_W + 4;
    localparam int SUM_HID    = MAN_W + 3;
    localparam int SUM_MAN_LO = 3;
    localparam int SUM_G      = 2;
    localparam int SUM_R      = 1;
    localparam int SUM_S      = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } bf16_t;
endpackage

// File: rtl/bf16_round.sv
// Round-to-nearest-even, overflow/FTZ underflow resolution and BF16 packing.
module bf16_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                       sign,
    input  logic signed [EXP_W+1:0]    exp,
    input  logic [MAN_W+2:0]           man,
    input  logic                       zero,
    input  logic                       special,
    input  logic [EXP_W+MAN_W:0]       special_data,
    output logic [EXP_W+MAN_W:0]       data,
    output logic                       of,
    output logic                       uf,
    output logic                       inexact
);
    localparam int XW   = EXP_W + 2;
    localparam int DW   = 1 + EXP_W + MAN_W;
    localparam int EMAX = (1 << EXP_W) - 1;

    logic             inc;
    logic [MAN_W:0]   rsum;
    logic signed [XW-1:0] r_exp;

    always_comb begin
        inc   = man[2] & (man[1] | man[0] | man[3]);
        rsum  = {1'b0, man[MAN_W+2:3]} + (MAN_W+1)'(inc);
        // A carry out of the stored mantissa wraps it to 0 and bumps the exponent
        r_exp = exp + XW'(rsum[MAN_W]);

        data    = {sign, r_exp[EXP_W-1:0], rsum[MAN_W-1:0]};
        of      = 1'b0;
        uf      = 1'b0;
        inexact = |man[2:0];
        if (special) begin
            data    = special_data;
            inexact = 1'b0;
        end else if (zero) begin
            data    = {sign, (DW-1)'(0)};
            inexact = 1'b0;
        end else if (r_exp >= $signed(XW'(EMAX))) begin
            data    = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of      = 1'b1;
            inexact = 1'b1;
        end else if (r_exp[XW-1] || r_exp == '0) begin
            data    = {sign, (DW-1)'(0)};
            uf      = 1'b1;
            inexact = 1'b1;
        end
    end
endmodule

// File: rtl/lzc.sv
// Leading-zero counter; count is W when the input is all zeros.
module lzc #(
    parameter int W = 16
) (
    input  logic [W-1:0]             in_vec,
    output logic [$clog2(W+1)-1:0]   cnt
);
    localparam int CW = $clog2(W + 1);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (in_vec[i]) cnt = CW'(W - 1 - i);
    end
endmodule

// File: rtl/bf16_norm.sv
// Two-stage normalize (lzc + shift) and round/pack stage for the BF16 adder, valid/ready.
module bf16_norm
    import bf16_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int LZC_W = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     sign_i,
    input  logic [EXP_W-1:0]         exp_i,
    input  logic [MAN_W+4:0]         sum_i,
    input  logic                     special_i,
    input  logic [EXP_W+MAN_W:0]     special_data_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [EXP_W+MAN_W:0]     out_data_o,
    output logic                     of_o,
    output logic                     uf_o,
    output logic                     inexact_o
);
    localparam int NW = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int CW = $clog2(LZC_W + 1);

    logic [2:1] vld_pipe;
    logic       s1_adv, s2_adv;

    assign s2_adv      = ~vld_pipe[2] | out_ready_i;
    assign s1_adv      = ~vld_pipe[1] | s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = vld_pipe[2];

    logic [LZC_W-1:0]     lzc_in;
    logic [CW-1:0]        lz;
    logic [NW-1:0]        n_man;
    logic signed [XW-1:0] n_exp;

    assign lzc_in = LZC_W'(sum_i[NW-1:0]) << (LZC_W - NW);

    lzc #(.W(LZC_W)) u_lzc (.in_vec(lzc_in), .cnt(lz));

    always_comb begin
        if (sum_i[NW]) begin
            n_man = {sum_i[NW:2], |sum_i[1:0]};
            n_exp = XW'(exp_i) + XW'(1);
        end else begin
            n_man = sum_i[NW-1:0] << lz;
            n_exp = XW'(exp_i) - XW'(lz);
        end
    end

    logic                 s1_sign, s1_zero, s1_special;
    logic signed [XW-1:0] s1_exp;
    logic [NW-2:0]        s1_man;
    logic [DW-1:0]        s1_sdata;
    logic [DW-1:0]        r_data;
    logic                 r_of, r_uf, r_inx;

    bf16_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign(s1_sign), .exp(s1_exp), .man(s1_man), .zero(s1_zero),
        .special(s1_special), .special_data(s1_sdata),
        .data(r_data), .of(r_of), .uf(r_uf), .inexact(r_inx)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_pipe   <= '0;
            s1_sign    <= 1'b0;
            s1_zero    <= 1'b0;
            s1_special <= 1'b0;
            s1_exp     <= '0;
            s1_man     <= '0;
            s1_sdata   <= '0;
            out_data_o <= '0;
            of_o       <= 1'b0;
            uf_o       <= 1'b0;
            inexact_o  <= 1'b0;
        end else begin
            if (s1_adv) vld_pipe[1] <= in_valid_i;
            if (s1_adv && in_valid_i) begin
                s1_sign    <= sign_i;
                // After normalization the hidden slot is clear only for an all-zero sum
                s1_zero    <= ~n_man[NW-1];
                s1_special <= special_i;
                s1_exp     <= n_exp;
                s1_man     <= n_man[NW-2:0];
                s1_sdata   <= special_data_i;
            end
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (s2_adv && vld_pipe[1]) begin
                out_data_o <= r_data;
                of_o       <= r_of;
                uf_o       <= r_uf;
                inexact_o  <= r_inx;
            end
        end
    end
endmodule

// File: tb/tb_bf16_norm.sv
// Bench for bf16_norm: directed vectors, backpressure, async reset and random traffic vs a value-level model.
module tb_bf16_norm;
    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid_i, in_ready_o, sign_i, special_i, out_ready_i;
    logic [7:0]  exp_i;
    logic [11:0] sum_i;
    logic [15:0] special_data_i;
    logic        out_valid_o, of_o, uf_o, inexact_o;
    logic [15:0] out_data_o;

    bf16_norm dut (
        .clk(clk), .nreset(nreset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sign_i(sign_i), .exp_i(exp_i), .sum_i(sum_i), .special_i(special_i),
        .special_data_i(special_data_i), .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .of_o(of_o), .uf_o(uf_o), .inexact_o(inexact_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [18:0] want; int cyc; } exp_t;
    exp_t sb[$];
    int   errors = 0, checks = 0, cyc = 0, n_out = 0;
    bit   lat_exact = 1'b1, stall_prev = 1'b0, done_rand;
    logic [18:0] prev_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Value-level reference: locate the MSB, keep 8 significant bits, RNE on the remainder.
    function automatic logic [18:0] model(bit s, logic [7:0] ex, logic [11:0] sum, bit sp, logic [15:0] sd);
        int mag, p, e, sh, keep, rem;
        bit inx;
        if (sp) return {sd, 3'b000};
        mag = int'(sum);
        if (mag == 0) return {s, 18'b0};
        p = 11;
        while (((mag >> p) & 1) == 0) p--;
        e    = int'(ex) + p - 10;
        sh   = (p > 7) ? p - 7 : 0;
        keep = (p >= 7) ? (mag >> sh) : (mag << (7 - p));
        rem  = mag & ((1 << sh) - 1);
        inx  = (rem != 0);
        if (2 * rem > (1 << sh) || (2 * rem == (1 << sh) && keep % 2 == 1)) keep++;
        if (keep == 256) begin keep = 128; e++; end
        if (e >= 255) return {s, 8'hFF, 7'd0, 3'b101};
        if (e <= 0)   return {s, 15'd0, 3'b011};
        return {s, e[7:0], keep[6:0], 2'b00, inx};
    endfunction

    task automatic send(input bit s, input logic [7:0] ex, input logic [11:0] sum, input bit sp,
                        input logic [15:0] sd, input bit have, input logic [18:0] want);
        int  n = 0;
        bit  ok = 1'b0;
        exp_t x;
        sign_i = s; exp_i = ex; sum_i = sum; special_i = sp; special_data_i = sd;
        in_valid_i = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready_o;
            n++;
        end
        if (!ok) chk("in_timeout", 0, 1);
        else begin
            x.want = have ? want : model(s, ex, sum, sp, sd);
            x.cyc  = cyc;
            sb.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t x;
        if (!nreset) stall_prev = 1'b0;
        else begin
            if (stall_prev)
                chk("stable", {out_valid_o, out_data_o, of_o, uf_o, inexact_o}, {1'b1, prev_out});
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) chk("spurious", 1, 0);
                else begin
                    x = sb.pop_front();
                    chk("data", out_data_o, x.want[18:3]);
                    chk("flags", {of_o, uf_o, inexact_o}, x.want[2:0]);
                    if (lat_exact) chk("latency", cyc - x.cyc, 2);
                    n_out++;
                end
            end
            stall_prev = out_valid_o & ~out_ready_i;
            prev_out   = {out_data_o, of_o, uf_o, inexact_o};
        end
    end

    initial begin
        int base;
        logic [11:0] rs;
        logic [7:0]  re;
        nreset = 1'b0; in_valid_i = 1'b0; sign_i = 1'b0; exp_i = '0; sum_i = '0;
        special_i = 1'b0; special_data_i = '0; out_ready_i = 1'b1;
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_out", {out_data_o, of_o, uf_o, inexact_o}, 0);
        repeat (2) @(posedge clk);
        #2 nreset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", in_ready_o, 1);

        // Directed vectors, out_ready_i held high
        send(0, 127, 12'b01_0000000_000, 0, 0, 1, {16'h3F80, 3'b000});
        send(0, 127, 12'b10_0000000_000, 0, 0, 1, {16'h4000, 3'b000});
        send(0, 127, 12'b00_0001000_000, 0, 0, 1, {16'h3D80, 3'b000});
        send(0, 127, 12'b01_0000001_100, 0, 0, 1, {16'h3F82, 3'b001});
        send(0, 127, 12'b01_1111111_101, 0, 0, 1, {16'h4000, 3'b001});
        send(0, 254, 12'b10_0000000_000, 0, 0, 1, {16'h7F80, 3'b101});
        send(1, 3,   12'b00_0001000_000, 0, 0, 1, {16'h8000, 3'b011});
        send(0, 127, 12'b0,              0, 0, 1, {16'h0000, 3'b000});
        send(0, 127, 12'b01_0101010_111, 1, 16'h7FC1, 1, {16'h7FC1, 3'b000});
        drain();

        // Backpressure: 5 back-to-back beats, out_ready_i low for 3 cycles
        lat_exact = 1'b0;
        base = n_out;
        out_ready_i = 1'b0;
        fork
            for (int i = 0; i < 5; i++)
                send(i[0], 8'(120 + i), 12'(12'h400 + 37 * i), 0, 0, 0, '0);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_ready", in_ready_o, 0);
                @(posedge clk); #1;
                out_ready_i = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_out - base, 5);

        // Asynchronous reset with both stages occupied
        out_ready_i = 1'b0;
        send(0, 127, 12'h400, 0, 0, 0, '0);
        send(0, 127, 12'h800, 0, 0, 0, '0);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid_o, 1);
        #2 nreset = 1'b0;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_out", {out_data_o, of_o, uf_o, inexact_o}, 0);
        sb.delete();
        repeat (2) begin @(negedge clk); chk("rst_hold_valid", out_valid_o, 0); end
        @(posedge clk); #2 nreset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready_o, 1);
        out_ready_i = 1'b1;
        lat_exact = 1'b1;
        send(0, 127, 12'b01_0000000_000, 0, 0, 1, {16'h3F80, 3'b000});
        drain();

        // Random traffic with random output stalls
        lat_exact = 1'b0;
        done_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin in_valid_i = 1'b0; @(posedge clk); #1; end
                    rs = 12'($urandom) >> $urandom_range(0, 12);
                    case ($urandom_range(0, 3))
                        0: re = 8'($urandom_range(0, 5));
                        1: re = 8'($urandom_range(250, 255));
                        default: re = 8'($urandom);
                    endcase
                    send(1'($urandom), re, rs, $urandom_range(0, 15) == 0, 16'($urandom), 0, '0);
                end
                in_valid_i = 1'b0;
                done_rand = 1'b1;
            end
            while (!done_rand) begin
                out_ready_i = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
